// File: rtl/pipe_defs.sv
// Shared definitions for the MEM stage: FSM encodings, bubble field values,
// default access timeout and a small alignment helper.
package pipe_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam int DEF_TIMEOUT = 16;

  localparam logic        BUBBLE_REG_WRITE  = 1'b0;
  localparam logic        BUBBLE_MEM_TO_REG = 1'b0;
  localparam logic [4:0]  BUBBLE_RD         = 5'd0;
  localparam logic [31:0] BUBBLE_DATA       = 32'd0;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM_WB pipeline register; a bubble replaces every field with the bubble values.
module mem_wb_reg
  import pipe_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_bubble,
  input  logic        i_mem_to_reg,
  input  logic        i_reg_write,
  input  logic [31:0] i_read_data,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_rd,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic [31:0] o_read_data,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd
);

  logic        r_mem_to_reg;
  logic        r_reg_write;
  logic [31:0] r_read_data;
  logic [31:0] r_result;
  logic [4:0]  r_rd;

  // Capture either the incoming instruction or a bubble every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_read_data  <= 32'd0;
      r_result     <= 32'd0;
      r_rd         <= 5'd0;
    end else if (i_bubble) begin
      r_mem_to_reg <= BUBBLE_MEM_TO_REG;
      r_reg_write  <= BUBBLE_REG_WRITE;
      r_read_data  <= BUBBLE_DATA;
      r_result     <= BUBBLE_DATA;
      r_rd         <= BUBBLE_RD;
    end else begin
      r_mem_to_reg <= i_mem_to_reg;
      r_reg_write  <= i_reg_write;
      r_read_data  <= i_read_data;
      r_result     <= i_result;
      r_rd         <= i_rd;
    end
  end

  assign o_mem_to_reg = r_mem_to_reg;
  assign o_reg_write  = r_reg_write;
  assign o_read_data  = r_read_data;
  assign o_result     = r_result;
  assign o_rd         = r_rd;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/ready data-memory port with
// timeout abort, upstream stall generation, branch redirect and the MEM_WB register.
module mem_access_stage
  import pipe_defs::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Mem_Read_EX_MEM,
  input  logic          Mem_Write_EX_MEM,
  input  logic          PcSrc_EX_MEM,
  input  logic          Mem_to_Reg_EX_MEM,
  input  logic          Reg_Write_EX_MEM,
  input  logic          zero_EX_MEM,
  input  logic [31:0]   PC_Branch_EX_MEM,
  input  logic [31:0]   result_EX_MEM,
  input  logic [31:0]   Write_Data_EX_MEM,
  input  logic [4:0]    rd_EX_MEM,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic [31:0]   dmem_rdata,
  input  logic          dmem_ready,
  output logic          stall,
  output logic          branch_taken,
  output logic [31:0]   PC_Branch_MEM,
  output logic          Mem_to_Reg_MEM_WB,
  output logic          Reg_Write_MEM_WB,
  output logic [31:0]   Read_Data_MEM_WB,
  output logic [31:0]   result_MEM_WB,
  output logic [4:0]    rd_MEM_WB,
  output logic          mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e    r_state;
  mem_state_e    w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          w_mem_op;
  logic          w_aligned;
  logic          w_stall;
  logic          w_bubble;
  logic          w_start;
  logic          w_done;
  logic          w_abort;
  logic          w_err_set;
  logic          w_last_wait;
  logic [31:0]   w_wb_read_data;

  assign w_mem_op    = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
  assign w_aligned   = is_word_aligned(result_EX_MEM[1:0]);
  assign w_last_wait = (r_cnt == CW'(TIMEOUT - 1));

  // Next-state, stall and MEM_WB control for the access FSM
  always_comb begin
    w_next_state   = r_state;
    w_stall        = 1'b0;
    w_bubble       = 1'b1;
    w_start        = 1'b0;
    w_done         = 1'b0;
    w_abort        = 1'b0;
    w_err_set      = 1'b0;
    w_wb_read_data = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          if (w_aligned) begin
            w_stall      = 1'b1;
            w_start      = 1'b1;
            w_next_state = ST_WAIT;
          end else begin
            w_err_set = 1'b1;
          end
        end else begin
          w_bubble = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          w_bubble       = 1'b0;
          w_done         = 1'b1;
          w_wb_read_data = r_we ? 32'd0 : dmem_rdata;
          w_next_state   = ST_IDLE;
        end else if (w_last_wait) begin
          w_abort      = 1'b1;
          w_err_set    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FSM state and WAIT-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_start || w_done || w_abort) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Request latch: address/data/we only change when a new access starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= {AW{1'b0}};
      r_wdata <= 32'd0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= Mem_Write_EX_MEM;
      r_addr  <= AW'(result_EX_MEM);
      r_wdata <= Write_Data_EX_MEM;
    end else if (w_done || w_abort) begin
      r_req <= 1'b0;
    end else begin
      r_req <= r_req;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  mem_wb_reg u_mem_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_bubble     (w_bubble),
    .i_mem_to_reg (Mem_to_Reg_EX_MEM),
    .i_reg_write  (Reg_Write_EX_MEM),
    .i_read_data  (w_wb_read_data),
    .i_result     (result_EX_MEM),
    .i_rd         (rd_EX_MEM),
    .o_mem_to_reg (Mem_to_Reg_MEM_WB),
    .o_reg_write  (Reg_Write_MEM_WB),
    .o_read_data  (Read_Data_MEM_WB),
    .o_result     (result_MEM_WB),
    .o_rd         (rd_MEM_WB)
  );

  // Combinational outputs are forced low while reset is held
  assign stall         = rst_n & w_stall;
  assign branch_taken  = rst_n & PcSrc_EX_MEM & zero_EX_MEM;
  assign PC_Branch_MEM = rst_n ? PC_Branch_EX_MEM : 32'd0;

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = r_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a queue-based MEM_WB scoreboard.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Mem_Read_EX_MEM, Mem_Write_EX_MEM, PcSrc_EX_MEM;
  logic        Mem_to_Reg_EX_MEM, Reg_Write_EX_MEM, zero_EX_MEM;
  logic [31:0] PC_Branch_EX_MEM, result_EX_MEM, Write_Data_EX_MEM;
  logic [4:0]  rd_EX_MEM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        stall, branch_taken;
  logic [31:0] PC_Branch_MEM;
  logic        Mem_to_Reg_MEM_WB, Reg_Write_MEM_WB;
  logic [31:0] Read_Data_MEM_WB, result_MEM_WB;
  logic [4:0]  rd_MEM_WB;
  logic        mem_err;

  typedef struct {
    logic        bubble;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] result;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_stage #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Mem_Read_EX_MEM(Mem_Read_EX_MEM), .Mem_Write_EX_MEM(Mem_Write_EX_MEM),
    .PcSrc_EX_MEM(PcSrc_EX_MEM), .Mem_to_Reg_EX_MEM(Mem_to_Reg_EX_MEM),
    .Reg_Write_EX_MEM(Reg_Write_EX_MEM), .zero_EX_MEM(zero_EX_MEM),
    .PC_Branch_EX_MEM(PC_Branch_EX_MEM), .result_EX_MEM(result_EX_MEM),
    .Write_Data_EX_MEM(Write_Data_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall(stall), .branch_taken(branch_taken), .PC_Branch_MEM(PC_Branch_MEM),
    .Mem_to_Reg_MEM_WB(Mem_to_Reg_MEM_WB), .Reg_Write_MEM_WB(Reg_Write_MEM_WB),
    .Read_Data_MEM_WB(Read_Data_MEM_WB), .result_MEM_WB(result_MEM_WB),
    .rd_MEM_WB(rd_MEM_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_nop();
    Mem_Read_EX_MEM   = 1'b0;
    Mem_Write_EX_MEM  = 1'b0;
    PcSrc_EX_MEM      = 1'b0;
    Mem_to_Reg_EX_MEM = 1'b0;
    Reg_Write_EX_MEM  = 1'b0;
    zero_EX_MEM       = 1'b0;
    PC_Branch_EX_MEM  = 32'd0;
    result_EX_MEM     = 32'd0;
    Write_Data_EX_MEM = 32'd0;
    rd_EX_MEM         = 5'd0;
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, "_qdepth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rw"},  32'(Reg_Write_MEM_WB),  32'(e.rw));
      chk({tag, "_m2r"}, 32'(Mem_to_Reg_MEM_WB), 32'(e.m2r));
      chk({tag, "_rd"},  32'(rd_MEM_WB),         32'(e.rd));
      if (!e.bubble) begin
        chk({tag, "_rdata"},  Read_Data_MEM_WB, e.rdata);
        chk({tag, "_result"}, result_MEM_WB,    e.result);
      end
    end
  endtask

  task automatic push_bubble();
    exp_t e;
    e.bubble = 1'b1; e.rw = 1'b0; e.m2r = 1'b0; e.rd = 5'd0;
    e.rdata = 32'd0; e.result = 32'd0;
    exp_q.push_back(e);
  endtask

  // Memory op whose ready arrives in WAIT cycle n (1 <= n < TO)
  task automatic do_mem(input logic rdn, input logic wrn, input logic m2r, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rdi, input int n, input logic [31:0] rdv,
                        input string tag);
    exp_t e;
    @(negedge clk);
    Mem_Read_EX_MEM = rdn; Mem_Write_EX_MEM = wrn; Mem_to_Reg_EX_MEM = m2r;
    Reg_Write_EX_MEM = rw; result_EX_MEM = addr; Write_Data_EX_MEM = wdata; rd_EX_MEM = rdi;
    e.bubble = 1'b0; e.rw = rw; e.m2r = m2r; e.rd = rdi;
    e.rdata = wrn ? 32'd0 : rdv; e.result = addr;
    exp_q.push_back(e);
    #1;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
    chk({tag, "_idle_req"}, 32'(dmem_req), 32'd0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == n) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdv;
      end
      #1;
      chk({tag, "_req"}, 32'(dmem_req), 32'd1);
      chk({tag, "_addr"}, dmem_addr, addr);
      chk({tag, "_we"}, 32'(dmem_we), 32'(wrn));
      chk({tag, "_wdata"}, dmem_wdata, wdata);
      chk({tag, "_stall"}, 32'(stall), (k == n) ? 32'd0 : 32'd1);
      chk({tag, "_wait_bubble"}, 32'(Reg_Write_MEM_WB), 32'd0);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    set_nop();
    #1;
    pop_cmp(tag);
    chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    set_nop();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    rst_n = 1'b0;
    Mem_Read_EX_MEM = 1'b1;
    result_EX_MEM = 32'hAAAAAAAA;
    rd_EX_MEM = 5'd31;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_branch", 32'(branch_taken), 32'd0);
    chk("rst_pcb", PC_Branch_MEM, 32'd0);
    chk("rst_wb_rw", 32'(Reg_Write_MEM_WB), 32'd0);
    chk("rst_wb_rd", 32'(rd_MEM_WB), 32'd0);
    chk("rst_wb_res", result_MEM_WB, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;

    // R-type passes straight through in one cycle
    @(negedge clk);
    Reg_Write_EX_MEM = 1'b1; result_EX_MEM = 32'hDEADBEEF; rd_EX_MEM = 5'd10;
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 5'd10, 32'd0, 32'hDEADBEEF});
    #1;
    chk("rtype_stall", 32'(stall), 32'd0);
    @(negedge clk);
    set_nop();
    #1;
    pop_cmp("rtype");

    do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE0000, 32'd0, 5'd11, 3, 32'h12345678, "load3");
    do_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h00001000, 32'h11111111, 5'd0, 1, 32'h55555555, "store");

    // Branch right after the store
    @(negedge clk);
    PcSrc_EX_MEM = 1'b1; zero_EX_MEM = 1'b1; PC_Branch_EX_MEM = 32'h00400020;
    push_bubble();
    exp_q[exp_q.size() - 1].bubble = 1'b0;
    exp_q[exp_q.size() - 1].result = 32'd0;
    #1;
    chk("br_taken", 32'(branch_taken), 32'd1);
    chk("br_pc", PC_Branch_MEM, 32'h00400020);
    chk("br_stall", 32'(stall), 32'd0);
    @(negedge clk);
    zero_EX_MEM = 1'b0;
    #1;
    chk("br_not_taken", 32'(branch_taken), 32'd0);
    pop_cmp("branch");
    set_nop();

    // Read and write together: write wins, no read data
    do_mem(1'b1, 1'b1, 1'b1, 1'b1, 32'h00000040, 32'hA5A5A5A5, 5'd12, 2, 32'h77777777, "rdwr");

    // Misaligned access
    @(negedge clk);
    #1;
    chk("mis_err_before", 32'(mem_err), 32'd0);
    Mem_Read_EX_MEM = 1'b1; Reg_Write_EX_MEM = 1'b1; result_EX_MEM = 32'h00000002; rd_EX_MEM = 5'd7;
    push_bubble();
    #1;
    chk("mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    set_nop();
    #1;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_err", 32'(mem_err), 32'd1);
    pop_cmp("mis");

    // Reset in the middle of WAIT
    @(negedge clk);
    Mem_Read_EX_MEM = 1'b1; Reg_Write_EX_MEM = 1'b1; result_EX_MEM = 32'h00000100; rd_EX_MEM = 5'd3;
    @(negedge clk);
    #1;
    chk("rw_req_up", 32'(dmem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rw_req_async", 32'(dmem_req), 32'd0);
    chk("rw_err_clr", 32'(mem_err), 32'd0);
    set_nop();
    @(negedge clk);
    #1;
    chk("rw_wb_rw", 32'(Reg_Write_MEM_WB), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rw_idle_req", 32'(dmem_req), 32'd0);
    chk("rw_idle_stall", 32'(stall), 32'd0);
    do_mem(1'b1, 1'b0, 1'b1, 1'b1, 32'h00000200, 32'd0, 5'd4, 2, 32'h0BADF00D, "fresh");

    // Timeout: ready never arrives
    @(negedge clk);
    Mem_Read_EX_MEM = 1'b1; Reg_Write_EX_MEM = 1'b1; result_EX_MEM = 32'h00002000; rd_EX_MEM = 5'd5;
    push_bubble();
    #1;
    chk("to_idle_stall", 32'(stall), 32'd1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      #1;
      chk("to_req", 32'(dmem_req), 32'd1);
      chk("to_stall", 32'(stall), (k == TO) ? 32'd0 : 32'd1);
      chk("to_err_pending", 32'(mem_err), 32'd0);
    end
    @(negedge clk);
    set_nop();
    #1;
    chk("to_err", 32'(mem_err), 32'd1);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    pop_cmp("timeout");
    @(negedge clk);
    #1;
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the 5-stage pipeline. It consumes the EX_MEM pipeline register outputs and performs word loads and stores against a variable-latency data memory using a req/ready handshake. It stalls the upstream pipeline while an access is outstanding and resolves branch redirection. It also owns the MEM_WB pipeline register that feeds write-back.

## Interface
- Parameters:
  - `TIMEOUT`, default 16: max WAIT cycles without `dmem_ready` before the access is aborted.
  - `AW`, default 32: data-memory address width.
- Ports:
  - `clk` in 1: single clock, rising edge.
  - `rst_n` in 1: reset, asynchronous and active-low.
  - `Mem_Read_EX_MEM`, `Mem_Write_EX_MEM`, `PcSrc_EX_MEM`, `Mem_to_Reg_EX_MEM`, `Reg_Write_EX_MEM`, `zero_EX_MEM` in 1 each: control from EX_MEM.
  - `PC_Branch_EX_MEM`, `result_EX_MEM`, `Write_Data_EX_MEM` in 32 each: branch target, ALU result/address, store data.
  - `rd_EX_MEM` in 5: destination register.
  - `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out AW, `dmem_wdata` out 32: memory request.
  - `dmem_rdata` in 32, `dmem_ready` in 1: memory response.
  - `stall` out 1: holds the EX_MEM register and everything upstream.
  - `branch_taken` out 1, `PC_Branch_MEM` out 32: PC redirect.
  - `Mem_to_Reg_MEM_WB`, `Reg_Write_MEM_WB` out 1 each.
  - `Read_Data_MEM_WB`, `result_MEM_WB` out 32 each.
  - `rd_MEM_WB` out 5.
  - `mem_err` out 1: sticky error flag.

## Operation
- States: IDLE, WAIT.
- `mem_op = Mem_Read_EX_MEM | Mem_Write_EX_MEM`.
- **IDLE, no `mem_op`:**
  - `stall` is 0.
  - MEM_WB captures the EX_MEM fields at the edge.
  - `Read_Data_MEM_WB` is loaded with 0.
- **IDLE, `mem_op`, address aligned (`result_EX_MEM[1:0]==0`):**
  - `stall` is 1 (combinational).
  - At the edge: latch `dmem_addr=result`, `dmem_wdata=Write_Data`, `dmem_we=Mem_Write_EX_MEM`. Set `dmem_req=1`, clear the timeout counter, go to WAIT.
  - MEM_WB loads a bubble (`Reg_Write=0`, `Mem_to_Reg=0`, `rd=0`).
- **IDLE, `mem_op`, misaligned:**
  - No request is issued and `stall` is 0.
  - `mem_err` is set.
  - MEM_WB loads a bubble.
- **WAIT, `dmem_ready=0`:**
  - `stall` is 1 and the counter increments.
  - MEM_WB loads a bubble.
  - `dmem_*` outputs hold stable.
- **WAIT, `dmem_ready=1`:**
  - `stall` is 0.
  - At the edge: MEM_WB captures the EX_MEM fields; `Read_Data_MEM_WB` gets `dmem_rdata` for a load, 0 for a store.
  - `dmem_req` goes to 0 and the FSM returns to IDLE.
- **WAIT, counter == TIMEOUT-1 and no ready:**
  - Abort the access and set `mem_err`.
  - MEM_WB loads a bubble, `dmem_req` goes to 0, return to IDLE.
  - `stall` is 0 in this cycle.
- **Read and Write both 1:** the write wins (`dmem_we=1`) and `Read_Data_MEM_WB=0`.
- **Branch:**
  - `branch_taken = PcSrc_EX_MEM & zero_EX_MEM` (combinational).
  - `PC_Branch_MEM = PC_Branch_EX_MEM`.
  - Branch instructions never carry `mem_op` and so never stall.
- `dmem_ready` is ignored in IDLE.
- `mem_err` clears only on reset.
- `rd_EX_MEM==0` with `Reg_Write` is passed through unchanged; the register file ignores x0.

## Timing
- **Reset:**
  - All outputs are 0: `stall`, `dmem_*`, `branch_taken`, `PC_Branch_MEM`, all `*_MEM_WB`, `mem_err`.
  - State goes to IDLE and the counter to 0.
- **Latency:**
  - Non-memory op: 1 cycle EX_MEM→MEM_WB.
  - Memory op: 1 + N cycles, where N ≥ 1 is WAIT cycles up to and including the `dmem_ready` cycle. Minimum is 2.
- **Handshake:**
  - `dmem_req` is registered and rises the cycle after the op is seen in IDLE.
  - The transfer completes on the first rising edge with `dmem_req & dmem_ready`.
  - Addr, data and `we` are held constant while `dmem_req` is 1.
- **Stall release:**
  - `stall` falls in the completion cycle, so EX_MEM advances on the same edge MEM_WB captures the result.
  - A back-to-back mem op is seen in IDLE on the next cycle; there is no idle gap on the bus beyond the IDLE cycle.
- **Reset mid-WAIT:** `dmem_req` drops asynchronously and no MEM_WB write occurs.
- **Timeout:** aborts on the edge ending the TIMEOUT-th WAIT cycle.

## Structure
- A shared package/header `pipe_defs` holds:
  - state encodings `ST_IDLE=1'b0`, `ST_WAIT=1'b1`
  - `BUBBLE` field constants
  - default `TIMEOUT`
- Sub-module `mem_wb_reg`: the MEM_WB pipeline register with a bubble-insert input and async active-low reset. The FSM, the request latch and the timeout counter stay in the top module.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with `Mem_Read=1`, `result=32'hAAAAAAAA`, `rd=31` → all outputs 0, `dmem_req=0`.
- **R-type:** `Reg_Write=1`, `result=32'hDEADBEEF`, `rd=10`, no `mem_op` → next edge `result_MEM_WB=DEADBEEF`, `rd_MEM_WB=10`, `stall` never 1.
- **Load, 3-cycle memory:** `Mem_Read=1`, `Mem_to_Reg=1`, `result=32'hCAFE0000`, `rd=11`; `dmem_ready` in the 3rd WAIT cycle with `rdata=32'h12345678`:
  - `stall` is high for 3 cycles; `dmem_addr=CAFE0000` is stable throughout.
  - Then `Read_Data_MEM_WB=12345678`, `rd_MEM_WB=11`.
  - Bubbles (`Reg_Write_MEM_WB=0`) appear during the stall.
- **Store then branch:** `Mem_Write=1`, `Write_Data=32'h11111111`, ready after 1 cycle; next instruction has `PcSrc=1`, `zero=1`, `PC_Branch=32'h00400020`:
  - `dmem_we=1`, `dmem_wdata=11111111`.
  - Then `branch_taken=1`, `PC_Branch_MEM=00400020`, `Reg_Write_MEM_WB=0`.
- **Timeout and misalignment:**
  - Load with `dmem_ready` stuck at 0 → after `TIMEOUT=16` WAIT cycles: `mem_err=1`, `stall=0`, bubble written.
  - Separately, `result=32'h00000002` with `Mem_Read=1` → no `dmem_req`, `mem_err=1`.
- **Reset mid-WAIT:** assert `rst_n=0` during WAIT → `dmem_req` falls asynchronously. After release, the state is IDLE and a fresh load completes normally.
